// File: rtl/int_ctrl.sv
// Interrupt controller: latches rising-edge requests, picks the lowest index,
// pauses the pipeline, redirects the PC to a vector and returns to the saved PC on mret.
module int_ctrl #(
    parameter int unsigned IRQ_NUM      = 4,
    parameter logic [31:0] VEC_BASE     = 32'h0000_0100,
    parameter int unsigned VEC_STRIDE   = 4,
    parameter int unsigned PAUSE_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic [IRQ_NUM-1:0]         irq,
    input  logic                       int_en,
    input  logic                       branch,
    input  logic                       mret,
    input  logic [31:0]                pc_resume,
    output logic                       int_set_pl_pause,
    output logic                       int_flag,
    output logic [31:0]                nextpc_int,
    output logic [31:0]                epc_out,
    output logic [$clog2(IRQ_NUM)-1:0] cause_out,
    output logic                       in_handler,
    output logic [IRQ_NUM-1:0]         irq_ack
);

    localparam int unsigned CW    = $clog2(IRQ_NUM);
    localparam int unsigned CNT_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        PAUSE,
        REDIRECT,
        HANDLER,
        RETURN
    } state_t;

    state_t             state, state_n;
    logic [IRQ_NUM-1:0] irq_d, pending, pending_n, ack_n;
    logic [CW-1:0]      lowest, cause_n;
    logic [31:0]        epc_n, nextpc_n;
    logic [CNT_W-1:0]   cnt, cnt_n;

    // Descending scan so the lowest set index is the last one written.
    always_comb begin
        lowest = '0;
        for (int unsigned i = IRQ_NUM; i > 0; i--) begin
            if (pending[i-1]) lowest = CW'(i - 1);
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        cause_n  = cause_out;
        epc_n    = epc_out;
        nextpc_n = nextpc_int;
        ack_n    = '0;
        case (state)
            IDLE: begin
                if (int_en && (|pending) && !branch && !mret) begin
                    cause_n = lowest;
                    epc_n   = pc_resume;
                    ack_n   = IRQ_NUM'(1) << lowest;
                    cnt_n   = CNT_W'(PAUSE_CYCLES - 1);
                    state_n = PAUSE;
                end
            end
            PAUSE: begin
                if (cnt == '0) begin
                    state_n  = REDIRECT;
                    nextpc_n = 32'(VEC_BASE + 32'(cause_out) * VEC_STRIDE);
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            REDIRECT: state_n = HANDLER;
            HANDLER: begin
                if (mret) begin
                    state_n  = RETURN;
                    nextpc_n = epc_out;
                end
            end
            RETURN:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // A new edge on a bit being acknowledged this cycle keeps it pending.
        pending_n = (pending & ~ack_n) | (irq & ~irq_d);
    end

    // Outputs are decoded from the next state so they are registered with it.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state            <= IDLE;
            cnt              <= '0;
            irq_d            <= '0;
            pending          <= '0;
            epc_out          <= '0;
            cause_out        <= '0;
            nextpc_int       <= '0;
            irq_ack          <= '0;
            int_set_pl_pause <= 1'b0;
            int_flag         <= 1'b0;
            in_handler       <= 1'b0;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            irq_d            <= irq;
            pending          <= pending_n;
            epc_out          <= epc_n;
            cause_out        <= cause_n;
            nextpc_int       <= nextpc_n;
            irq_ack          <= ack_n;
            int_set_pl_pause <= (state_n == PAUSE);
            int_flag         <= (state_n == REDIRECT) || (state_n == RETURN);
            in_handler       <= (state_n == HANDLER) || (state_n == RETURN);
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: a timeline model of the interrupt sequence checked every cycle,
// plus directed scenarios with literal expectations.
module tb_int_ctrl;

    localparam int unsigned PC = 2;
    localparam logic [31:0] VB = 32'h0000_0100;
    localparam int unsigned VS = 4;

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  irq;
    logic        int_en, branch, mret;
    logic [31:0] pc_resume;
    logic        int_set_pl_pause, int_flag, in_handler;
    logic [31:0] nextpc_int, epc_out;
    logic [1:0]  cause_out;
    logic [3:0]  irq_ack;

    int n_cmp = 0;
    int n_bad = 0;

    int_ctrl #(.IRQ_NUM(4), .VEC_BASE(VB), .VEC_STRIDE(VS), .PAUSE_CYCLES(PC)) dut (
        .clk(clk), .clr(clr), .irq(irq), .int_en(int_en), .branch(branch), .mret(mret),
        .pc_resume(pc_resume), .int_set_pl_pause(int_set_pl_pause), .int_flag(int_flag),
        .nextpc_int(nextpc_int), .epc_out(epc_out), .cause_out(cause_out),
        .in_handler(in_handler), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 in the accept->redirect timeline (k = cycles since accept),
    // 2 handler, 3 return pulse.
    typedef struct packed {
        logic [3:0]  pend;
        logic [3:0]  prev;
        logic [1:0]  mode;
        logic [7:0]  k;
        logic [3:0]  ack;
        logic        pause;
        logic        flag;
        logic        inh;
        logic [31:0] npc;
        logic [31:0] epc;
        logic [1:0]  cause;
    } m_t;

    m_t m;

    function automatic m_t step(m_t s, logic [3:0] ir, logic en, logic br, logic mr,
                                logic [31:0] pcr);
        m_t n;
        int idx;
        n = s;
        n.prev  = ir;
        n.ack   = '0;
        n.pause = 1'b0;
        n.flag  = 1'b0;
        case (s.mode)
            2'd0: if (en && s.pend != 4'd0 && !br && !mr) begin
                idx = 0;
                for (int i = 3; i >= 0; i--) if (s.pend[i]) idx = i;
                n.cause     = 2'(idx);
                n.epc       = pcr;
                n.ack       = 4'(1 << idx);
                n.pend[idx] = 1'b0;
                n.mode      = 2'd1;
                n.k         = 8'd1;
                n.pause     = 1'b1;
            end
            2'd1: begin
                n.k = s.k + 8'd1;
                if (n.k <= 8'(PC)) n.pause = 1'b1;
                else if (n.k == 8'(PC + 1)) begin
                    n.flag = 1'b1;
                    n.npc  = VB + 32'(s.cause) * VS;
                end else begin
                    n.mode = 2'd2;
                    n.inh  = 1'b1;
                end
            end
            2'd2: if (mr) begin
                n.mode = 2'd3;
                n.flag = 1'b1;
                n.npc  = s.epc;
            end
            default: begin
                n.mode = 2'd0;
                n.inh  = 1'b0;
            end
        endcase
        n.pend = n.pend | (ir & ~s.prev);
        return n;
    endfunction

    always @(posedge clk or posedge clr) begin
        if (clr) m <= '0;
        else     m <= step(m, irq, int_en, branch, mret, pc_resume);
    end

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_flag(input string name);
        int n;
        n = 0;
        do begin
            nxt;
            n++;
        end while (!int_flag && n < 20);
        chk({name, "_flag_seen"}, 32'(int_flag), 32'd1);
    endtask

    initial begin
        int acks, flags;
        clr = 1'b1; irq = '0; int_en = 1'b1; branch = 1'b0; mret = 1'b0; pc_resume = 32'h40;

        fork
            forever begin
                @(negedge clk);
                if (!clr) begin
                    n_cmp++;
                    if (irq_ack !== m.ack || int_set_pl_pause !== m.pause || int_flag !== m.flag ||
                        in_handler !== m.inh || nextpc_int !== m.npc || epc_out !== m.epc ||
                        cause_out !== m.cause) begin
                        n_bad++;
                        $display("FAIL cycle@%0t: got ack=%b p=%b f=%b h=%b npc=%h epc=%h c=%0d want ack=%b p=%b f=%b h=%b npc=%h epc=%h c=%0d",
                                 $time, irq_ack, int_set_pl_pause, int_flag, in_handler, nextpc_int,
                                 epc_out, cause_out, m.ack, m.pause, m.flag, m.inh, m.npc, m.epc, m.cause);
                    end
                    if (int_set_pl_pause && int_flag) begin
                        n_bad++;
                        $display("FAIL pause_and_flag: got both 1 want exclusive");
                    end
                end
            end
        join_none

        #12;
        chk("reset_outs", {int_set_pl_pause, int_flag, in_handler, cause_out, irq_ack}, 32'd0);
        chk("reset_npc", nextpc_int, 32'd0);
        chk("reset_epc", epc_out, 32'd0);
        nxt; clr = 1'b0;
        nxt; nxt;

        // Single request on irq[2]
        irq = 4'b0100;
        nxt; chk("t1_c1_pause", 32'(int_set_pl_pause), 32'd0);
        nxt; chk("t1_c2_ack", 32'(irq_ack), 32'h4); chk("t1_c2_pause", 32'(int_set_pl_pause), 32'd1);
        nxt; chk("t1_c3_pause", 32'(int_set_pl_pause), 32'd1); chk("t1_c3_ack", 32'(irq_ack), 32'd0);
        nxt; chk("t1_c4_flag", 32'(int_flag), 32'd1); chk("t1_c4_npc", nextpc_int, 32'h108);
        chk("t1_epc", epc_out, 32'h40); chk("t1_cause", 32'(cause_out), 32'd2);
        nxt; chk("t1_c5_inh", 32'(in_handler), 32'd1); chk("t1_c5_flag", 32'(int_flag), 32'd0);
        irq = '0;
        nxt; nxt; nxt;
        mret = 1'b1; nxt; mret = 1'b0;
        chk("t1_ret_flag", 32'(int_flag), 32'd1); chk("t1_ret_npc", nextpc_int, 32'h40);
        chk("t1_ret_inh", 32'(in_handler), 32'd1);
        nxt; chk("t1_idle_inh", 32'(in_handler), 32'd0);

        // Priority: irq[3] and irq[1] together
        nxt; irq = 4'b1010;
        wait_flag("t2a");
        chk("t2_cause", 32'(cause_out), 32'd1); chk("t2_npc", nextpc_int, 32'h104);
        irq = '0;
        nxt; nxt;
        mret = 1'b1; nxt; mret = 1'b0;
        chk("t2_ret_npc", nextpc_int, 32'h40);
        wait_flag("t2b");
        chk("t2b_npc", nextpc_int, 32'h10C); chk("t2b_cause", 32'(cause_out), 32'd3);
        nxt; nxt; mret = 1'b1; nxt; mret = 1'b0; nxt; nxt;

        // Blocking by int_en and branch
        pc_resume = 32'h200; int_en = 1'b0; irq = 4'b0001;
        nxt; irq = '0;
        repeat (4) nxt;
        chk("t3_blocked_en", 32'(int_set_pl_pause), 32'd0);
        int_en = 1'b1; branch = 1'b1;
        nxt; nxt;
        chk("t3_blocked_br", {int_set_pl_pause, irq_ack}, 32'd0);
        branch = 1'b0;
        nxt; chk("t3_ack", 32'(irq_ack), 32'h1); chk("t3_pause", 32'(int_set_pl_pause), 32'd1);
        wait_flag("t3");

        // Nesting blocked; branch ignored in handler; mret beats branch
        nxt; irq = 4'b0001;
        nxt; irq = '0; branch = 1'b1;
        nxt; branch = 1'b0;
        nxt; chk("t4_no_pause", 32'(int_set_pl_pause), 32'd0); chk("t4_inh", 32'(in_handler), 32'd1);
        mret = 1'b1; branch = 1'b1;
        nxt; mret = 1'b0; branch = 1'b0;
        chk("t4_ret_flag", 32'(int_flag), 32'd1); chk("t4_ret_npc", nextpc_int, 32'h200);
        nxt; chk("t4_idle", {int_set_pl_pause, in_handler}, 32'd0);
        nxt; chk("t4_ack", 32'(irq_ack), 32'h1); chk("t4_pause", 32'(int_set_pl_pause), 32'd1);
        wait_flag("t4");
        nxt; nxt; mret = 1'b1; nxt; mret = 1'b0; nxt; nxt;

        // Held level on irq[1]
        irq = 4'b0010; acks = 0;
        for (int i = 0; i < 25; i++) begin
            nxt;
            if (irq_ack[1]) acks++;
            mret = (i == 8);
            if (i == 19) irq = '0;
        end
        mret = 1'b0;
        chk("t5_ack_count", 32'(acks), 32'd1); chk("t5_cause", 32'(cause_out), 32'd1);

        // Async reset during PAUSE
        nxt; irq = 4'b0100;
        nxt; nxt;
        chk("t6_pause", 32'(int_set_pl_pause), 32'd1);
        clr = 1'b1; #1;
        chk("t6_rst_outs", {int_set_pl_pause, int_flag, in_handler, cause_out, irq_ack}, 32'd0);
        chk("t6_rst_epc", epc_out, 32'd0);
        irq = '0;
        nxt; clr = 1'b0;
        flags = 0; acks = 0;
        repeat (8) begin
            nxt;
            if (int_flag) flags++;
            if (irq_ack != 4'd0) acks++;
        end
        chk("t6_no_flag", 32'(flags), 32'd0); chk("t6_pend_clr", 32'(acks), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
